// File: rtl/enable_sync_launcher.sv
// Source-domain launcher: registers a word, then raises a qualifying enable once the bus is stable.
// Optional macro ACK_HANDSHAKE_EN adds a synchronized ack_in for a 4-phase handshake.
module enable_sync_launcher #(
  parameter int DATA_WIDTH  = 5,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  en_out,
  output logic                  busy,
  output logic [7:0]            launch_cnt
`ifdef ACK_HANDSHAKE_EN
  ,
  input  logic                  ack_in
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("enable_sync_launcher: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("enable_sync_launcher: GAP_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("enable_sync_launcher: SYNC_STAGES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, GAP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    en_nxt;
  logic [7:0]              lcnt_nxt;
  logic                    hold_exit, gap_exit;

  // Counter stops at its terminal value so an ack-extended phase cannot wrap it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v == lim) ? v : v + CNT_W'(1);
  endfunction

`ifdef ACK_HANDSHAKE_EN
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign hold_exit = (cnt == HOLD_LAST) && ack_s;
  assign gap_exit  = (cnt == GAP_LAST) && !ack_s;
`else
  assign hold_exit = (cnt == HOLD_LAST);
  assign gap_exit  = (cnt == GAP_LAST);
`endif

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    en_nxt    = en_out;
    lcnt_nxt  = launch_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in_data;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      // Bus has been stable for one full cycle here, so the enable may rise.
      LOAD: begin
        en_nxt    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_exit) begin
          en_nxt    = 1'b0;
          lcnt_nxt  = launch_cnt + 8'd1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = sat_inc(cnt, HOLD_LAST);
        end
      end
      GAP: begin
        if (gap_exit) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = sat_inc(cnt, GAP_LAST);
        end
      end
      default: begin
        en_nxt    = 1'b0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_out   <= '0;
      en_out     <= 1'b0;
      launch_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      data_out   <= data_nxt;
      en_out     <= en_nxt;
      launch_cnt <= lcnt_nxt;
    end
  end

endmodule

// File: tb/tb_enable_sync_launcher.sv
// Directed bench for enable_sync_launcher at default parameters (5-bit data, HOLD=4, GAP=2).
module tb_enable_sync_launcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic [4:0] data_out;
  logic       en_out;
  logic       busy;
  logic [7:0] launch_cnt;
`ifdef ACK_HANDSHAKE_EN
  logic       ack_in = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  enable_sync_launcher #(
    .DATA_WIDTH (5),
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .en_out    (en_out),
    .busy      (busy),
    .launch_cnt(launch_cnt)
`ifdef ACK_HANDSHAKE_EN
    ,
    .ack_in    (ack_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 5'h00;
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(en_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_cnt", 32'(launch_cnt), 32'd0);
    rst = 1'b0;

    // Single word 5'h15 accepted at edge k
    in_valid = 1'b1;
    in_data  = 5'h15;
    step();
    in_valid = 1'b0;
    in_data  = 5'h00;
    chk("single_data_k", 32'(data_out), 32'h15);
    chk("single_en_k", 32'(en_out), 32'd0);
    chk("single_ready_k", 32'(in_ready), 32'd0);
    chk("single_busy_k", 32'(busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("single_en_hold", 32'(en_out), 32'd1);
      chk("single_data_hold", 32'(data_out), 32'h15);
    end
    step();
    chk("single_en_k5", 32'(en_out), 32'd0);
    chk("single_cnt_k5", 32'(launch_cnt), 32'd1);
    chk("single_data_k5", 32'(data_out), 32'h15);
    step();
    chk("single_ready_k6", 32'(in_ready), 32'd0);
    step();
    chk("single_ready_k7", 32'(in_ready), 32'd1);
    chk("single_cnt_k7", 32'(launch_cnt), 32'd1);

    // Back-to-back: 5'h01 then 5'h1E with in_valid held
    in_valid = 1'b1;
    in_data  = 5'h01;
    step();
    chk("b2b_first", 32'(data_out), 32'h01);
    in_data = 5'h1E;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("b2b_data_held", 32'(data_out), 32'h01);
      chk("b2b_ready", 32'(in_ready), (i == 7) ? 32'd1 : 32'd0);
      chk("b2b_en", 32'(en_out), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
    end
    step();
    in_valid = 1'b0;
    chk("b2b_second", 32'(data_out), 32'h1E);
    chk("b2b_second_en", 32'(en_out), 32'd0);
    for (int i = 1; i <= 7; i++) step();
    chk("b2b_ready_end", 32'(in_ready), 32'd1);
    chk("b2b_cnt", 32'(launch_cnt), 32'd3);

    // Ignored input: in_data toggles during LOAD/HOLD/GAP with in_valid high
    in_valid = 1'b1;
    in_data  = 5'h0A;
    step();
    chk("ign_accept", 32'(data_out), 32'h0A);
    for (int i = 1; i <= 7; i++) begin
      in_data = 5'(i * 7);
      if (i == 7) in_valid = 1'b0;
      step();
      chk("ign_data", 32'(data_out), 32'h0A);
      chk("ign_ready", 32'(in_ready), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("ign_cnt", 32'(launch_cnt), 32'd4);

    // Asynchronous reset asserted mid-HOLD
    in_valid = 1'b1;
    in_data  = 5'h1B;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("midrst_pre_en", 32'(en_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en", 32'(en_out), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_cnt", 32'(launch_cnt), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;

    // Wrap: 257 back-to-back launches from a cleared counter
    in_valid = 1'b1;
    in_data  = 5'h11;
    for (int n = 1; n <= 257; n++) begin
      step();
      for (int i = 1; i <= 7; i++) step();
      if (n == 1)   chk("wrap_cnt_1", 32'(launch_cnt), 32'd1);
      if (n == 255) chk("wrap_cnt_255", 32'(launch_cnt), 32'd255);
      if (n == 256) chk("wrap_cnt_256", 32'(launch_cnt), 32'd0);
      if (n == 257) chk("wrap_cnt_257", 32'(launch_cnt), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("final_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
